// File: rtl/eth_pkg.sv
// eth_pkg: shared FSM state encoding and default buffer depth for the ICMP echo path
package eth_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, START, SEND, WAIT_DONE} echo_state_t;
  localparam int ECHO_ADDR_W = 10;
endpackage

// File: rtl/icmp_echo_ram.sv
// icmp_echo_ram: simple dual-port byte RAM with synchronous, resettable read register
module icmp_echo_ram
  import eth_pkg::*;
#(
  parameter int ADDR_W = ECHO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  logic [7:0] mem [0:2**ADDR_W-1];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/icmp_echo_buf.sv
// icmp_echo_buf: ICMP echo payload capture/replay buffer; define ICMP_ECHO_STATS_EN for echo_cnt/drop_cnt
module icmp_echo_buf
  import eth_pkg::*;
#(
  parameter int ADDR_W     = ECHO_ADDR_W,
  parameter int TX_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [15:0] echo_cnt,
  output logic [15:0] drop_cnt
);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  echo_state_t state, state_n;
  logic [ADDR_W:0] wr_ptr, cnt_now;
  logic [ADDR_W-1:0] rd_ptr;
  logic [TW-1:0] to_cnt;
  logic ovf, ovf_now, in_rx, in_tx, room, wr_en, rd_en, at_end, accept, timeout;
  always_comb begin
    in_rx   = state == IDLE || state == CAPTURE;
    in_tx   = state == SEND || state == WAIT_DONE;
    room    = !wr_ptr[ADDR_W];
    wr_en   = in_rx && rec_en && room;
    cnt_now = wr_ptr + (ADDR_W+1)'(wr_en);
    ovf_now = ovf || (in_rx && rec_en && !room);
    accept  = !ovf_now && cnt_now != '0 && 32'(cnt_now) == 32'(rec_byte_num);
    rd_en   = in_tx && tx_req;
    at_end  = 32'(rd_ptr) + 1 >= 32'(tx_byte_num);
    timeout = in_tx && to_cnt == TW'(TX_TIMEOUT);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, CAPTURE:   state_n = rec_pkt_done ? (accept ? START : IDLE) : (rec_en ? CAPTURE : state);
      START:           state_n = SEND;
      SEND, WAIT_DONE: state_n = tx_done || timeout ? IDLE : (state == SEND && rd_en && at_end ? WAIT_DONE : state);
      default:         state_n = IDLE;
    endcase
  end
  always_comb begin
    tx_start_en = state == START;
    busy        = state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf         <= 1'b0;
      to_cnt      <= '0;
      tx_byte_num <= '0;
    end else begin
      wr_ptr      <= in_rx && !rec_pkt_done ? cnt_now : '0;
      ovf         <= in_rx && !rec_pkt_done && ovf_now;
      rd_ptr      <= state == START ? '0 : (rd_en && !at_end ? rd_ptr + ADDR_W'(1) : rd_ptr);
      to_cnt      <= in_tx && !tx_req ? to_cnt + TW'(1) : '0;
      tx_byte_num <= in_rx && rec_pkt_done && accept ? rec_byte_num : tx_byte_num;
    end
  icmp_echo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (rec_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (tx_data)
  );
`ifdef ICMP_ECHO_STATS_EN
  logic [15:0] echo_q, drop_q;
  logic rx_drop, busy_drop;
  always_comb begin
    rx_drop   = in_rx && rec_pkt_done && !accept;
    busy_drop = !in_rx && rec_pkt_done;
  end
  always_ff @(posedge clk)
    if (rst) begin
      echo_q <= '0;
      drop_q <= '0;
    end else begin
      echo_q <= echo_q + 16'(in_tx && tx_done);
      drop_q <= drop_q + 16'(rx_drop || busy_drop) + 16'(timeout && !tx_done);
    end
  assign echo_cnt = echo_q;
  assign drop_cnt = drop_q;
`else
  assign echo_cnt = '0;
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_icmp_echo_buf.sv
// tb_icmp_echo_buf: table-driven, hand-sequenced and randomized self-checking bench for icmp_echo_buf
module tb_icmp_echo_buf;
  localparam int AW = 5, DEPTH = 32, TMO = 100;
  logic clk = 1'b0;
  logic rst, rec_en, rec_pkt_done, tx_req, tx_done, tx_start_en, busy;
  logic [7:0] rec_data, tx_data;
  logic [15:0] rec_byte_num, tx_byte_num, echo_cnt, drop_cnt;
  int n_cmp = 0, n_bad = 0, exp_echo = 0, exp_drop = 0, k, len, num;
  bit acc;
  logic [7:0] pay [$];
  typedef struct {int len; int delta; bit same; bit pat; bit accept;} vec_t;
  vec_t vecs [8];
  always #5 clk = ~clk;
  icmp_echo_buf #(.ADDR_W(AW), .TX_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_data      (tx_data),
    .busy         (busy),
    .echo_cnt     (echo_cnt),
    .drop_cnt     (drop_cnt)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] cexp(input int v);
`ifdef ICMP_ECHO_STATS_EN
    return 16'(v);
`else
    return 16'h0;
`endif
  endfunction
  task automatic check_cnts;
    check("echo_cnt", echo_cnt, cexp(exp_echo));
    check("drop_cnt", drop_cnt, cexp(exp_drop));
  endtask
  task automatic send(input int n, input int nb, input bit same, input bit pat);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(pat ? 8'(i) : 8'($urandom));
    rec_byte_num = 16'(nb);
    for (int i = 0; i < n; i++) begin
      rec_en = 1'b1;
      rec_data = pay[i];
      rec_pkt_done = same && i == n - 1;
      tick;
    end
    rec_en = 1'b0;
    if (!(same && n > 0)) begin
      rec_pkt_done = 1'b1;
      tick;
    end
    rec_pkt_done = 1'b0;
  endtask
  task automatic read_back(input int first, input int n, input int gap);
    int sz;
    sz = pay.size();
    for (int i = first; i < first + n; i++) begin
      tx_req = 1'b1;
      tick;
      tx_req = 1'b0;
      check("tx_data", tx_data, pay[i < sz ? i : sz - 1]);
      repeat ($urandom_range(0, gap)) tick;
    end
  endtask
  task automatic finish_reply(input bit with_rec);
    tx_done = 1'b1;
    rec_en = with_rec;
    rec_data = 8'hAA;
    tick;
    tx_done = 1'b0;
    rec_en = 1'b0;
    exp_echo++;
    check("busy_after_done", busy, 0);
    check_cnts;
  endtask
  task automatic run(input int n, input int nb, input bit same, input bit pat, input int extra, input int gap, input bit exp_acc);
    send(n, nb, same, pat);
    check("accept", tx_start_en, exp_acc);
    if (exp_acc) begin
      check("tx_byte_num", tx_byte_num, 16'(nb));
      tick;
      check("start_one_cycle", tx_start_en, 0);
      read_back(0, n + extra, gap);
      finish_reply(1'b0);
    end else begin
      exp_drop++;
      check("busy_after_drop", busy, 0);
      check_cnts;
    end
  endtask
  initial begin
    rst = 1'b1; rec_en = 1'b0; rec_pkt_done = 1'b0; rec_data = '0;
    rec_byte_num = '0; tx_req = 1'b0; tx_done = 1'b0;
    repeat (3) tick;
    check("rst_tx_start_en", tx_start_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_byte_num", tx_byte_num, 0);
    check("rst_busy", busy, 0);
    check_cnts;
    rst = 1'b0;
    tick;
    vecs = '{'{32, 0, 0, 1, 1}, '{10, 2, 0, 0, 0}, '{33, 0, 0, 1, 0}, '{32, 0, 1, 0, 1},
             '{0, 0, 0, 0, 0}, '{1, 0, 1, 0, 1}, '{5, -1, 1, 0, 0}, '{16, 0, 0, 0, 1}};
    for (int i = 0; i < 8; i++)
      run(vecs[i].len, vecs[i].len + vecs[i].delta, vecs[i].same, vecs[i].pat, (i % 2) * 2, 0, vecs[i].accept);
    send(12, 12, 0, 0);
    check("busy_drop_accept", tx_start_en, 1);
    tick;
    read_back(0, 5, 0);
    for (int i = 0; i < 3; i++) begin
      rec_en = 1'b1;
      rec_data = 8'h55;
      tick;
    end
    rec_en = 1'b0;
    rec_pkt_done = 1'b1;
    rec_byte_num = 16'd3;
    tick;
    rec_pkt_done = 1'b0;
    exp_drop++;
    check("busy_during_drop", busy, 1);
    check_cnts;
    read_back(5, 7, 0);
    finish_reply(1'b1);
    run(4, 4, 0, 0, 0, 0, 1);
    send(6, 6, 0, 0);
    check("timeout_accept", tx_start_en, 1);
    repeat (TMO) tick;
    check("busy_before_timeout", busy, 1);
    k = 0;
    while (busy && k < 5) begin
      tick;
      k++;
    end
    check("timeout_idle", busy, 0);
    exp_drop++;
    check_cnts;
    send(20, 20, 0, 1);
    check("reset_accept", tx_start_en, 1);
    tick;
    read_back(0, 4, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_tx_start_en", tx_start_en, 0);
    check("rst_mid_tx_data", tx_data, 0);
    check("rst_mid_tx_byte_num", tx_byte_num, 0);
    check("rst_mid_busy", busy, 0);
    exp_echo = 0;
    exp_drop = 0;
    check_cnts;
    tick;
    run(8, 8, 0, 0, 0, 0, 1);
    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(0, DEPTH + 1);
      num = $urandom_range(0, 3) == 0 ? len + ($urandom_range(0, 1) ? 1 : -1) : len;
      acc = len > 0 && len <= DEPTH && num == len;
      run(len, num, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 2), 3, acc);
      repeat ($urandom_range(0, 2)) tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
